// File: rtl/uart_tx_fifo_if.sv
// Byte handshake between a producer and the UART transmitter FIFO.
// The producer drives in_data/in_valid; the transmitter answers with in_ready.
interface uart_tx_fifo_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a byte FIFO: start, 8 data bits LSB first, 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to add an even-parity bit after the data bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int STOP_BITS       = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  uart_tx_fifo_if.slave            host,
  output logic                     tx,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);
  localparam int CNT_W = 11;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CNT_W-1:0]           BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]           CNT_INC   = CNT_W'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE   = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE   = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [2:0]                 bit_idx, bit_nxt;
  logic                       tx_nxt;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr, rptr;
  logic [7:0]                 shift_p0;
  logic                       full, empty, push, pop, shift_en;
`ifdef UART_TX_PARITY_EN
  logic                       par_p0;
`endif

  assign full          = (fifo_count == FULL_CNT);
  assign empty         = (fifo_count == '0);
  assign host.in_ready = !full;
  assign push          = host.in_valid && !full;
  assign busy          = (state != IDLE) || !empty;

  // FIFO bookkeeping; a simultaneous push and pop leaves the count alone
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_ONE;
        2'b01:   fifo_count <= fifo_count - CNT_ONE;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wptr] <= host.in_data;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_INC;
    bit_nxt   = bit_idx;
    tx_nxt    = tx;
    pop       = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        tx_nxt  = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: if (cnt == BIT_LAST) begin
        cnt_nxt   = '0;
        bit_nxt   = '0;
        tx_nxt    = shift_p0[0];
        state_nxt = DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_nxt = '0;
        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          tx_nxt    = par_p0;
          state_nxt = PARITY;
`else
          tx_nxt    = 1'b1;
          state_nxt = STOP;
`endif
        end else begin
          // shift_p0[1] becomes the new LSB once the register shifts
          shift_en = 1'b1;
          tx_nxt   = shift_p0[1];
          bit_nxt  = bit_idx + 3'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (cnt == BIT_LAST) begin
        cnt_nxt   = '0;
        tx_nxt    = 1'b1;
        state_nxt = STOP;
      end
`endif
      STOP: if (cnt == STOP_LAST) begin
        cnt_nxt = '0;
        if (!empty) begin
          pop       = 1'b1;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end else begin
          tx_nxt    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      tx      <= tx_nxt;
    end
  end

  // Popped byte lands in the shift register; parity is taken before any shifting
  always_ff @(posedge CLOCK_50) begin
    if (pop) begin
      shift_p0 <= mem[rptr];
`ifdef UART_TX_PARITY_EN
      par_p0   <= ^mem[rptr];
`endif
    end else if (shift_en) begin
      shift_p0 <= {1'b0, shift_p0[7:1]};
    end
  end
endmodule
